// File: rtl/ooo_read_responder_if.sv
// AR/R ID-tagged read channel bundle between a requester (master) and the responder (slave).
interface ooo_read_responder_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [3:0]            s_arid_i;
  logic                  s_arvalid_i;
  logic                  s_arready_o;
  logic [DATA_WIDTH-1:0] s_rdata_o;
  logic [3:0]            s_rid_o;
  logic                  s_rvalid_o;
  logic                  s_rready_i;

  modport slave (
    input  s_arid_i, s_arvalid_i, s_rready_i,
    output s_arready_o, s_rdata_o, s_rid_o, s_rvalid_o
  );

  modport master (
    output s_arid_i, s_arvalid_i, s_rready_i,
    input  s_arready_o, s_rdata_o, s_rid_o, s_rvalid_o
  );
endinterface

// File: rtl/ooo_read_responder.sv
// Read responder: holds up to DEPTH AR requests and returns R beats out of order
// after per-request delays; rdata carries the accept sequence number.
module ooo_read_responder #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned MAX_LAT    = 7,
  parameter int unsigned LAT_MODE   = 0,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
  input logic              clk,
  input logic              rst,
  ooo_read_responder_if.slave s
);

  localparam int unsigned PTR_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W       = 8;
  localparam logic [7:0]  LFSR_TAPS   = 8'hB8;
  localparam logic [7:0]  LFSR_INIT   = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  localparam logic [7:0]  MAX_LAT_CNT = 8'(MAX_LAT);

  typedef enum logic [1:0] {
    SLOT_FREE,
    SLOT_PEND,
    SLOT_READY
  } slot_state_e;

  typedef struct packed {
    logic [3:0]            id;
    logic [DATA_WIDTH-1:0] seq;
    logic [CNT_W-1:0]      cnt;
  } slot_t;

  slot_state_e           state_q [DEPTH];
  slot_state_e           state_d [DEPTH];
  slot_t                 slot_q  [DEPTH];
  slot_t                 slot_d  [DEPTH];
  logic [DATA_WIDTH-1:0] seq_cnt_q, seq_cnt_d;
  logic [7:0]            lfsr_q, lfsr_d;
  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic [3:0]            rid_q, rid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic                  accept;
  logic                  load_en;
  logic                  alloc_found;
  logic [PTR_W-1:0]      alloc_idx;
  logic                  grant_found;
  logic [PTR_W-1:0]      grant_idx;
  logic [PTR_W-1:0]      cand;
  logic [CNT_W-1:0]      new_cnt;

  assign s.s_arready_o = arready_q;
  assign s.s_rvalid_o  = rvalid_q;
  assign s.s_rid_o     = rid_q;
  assign s.s_rdata_o   = rdata_q;

  // Next-state: countdown, allocation, round-robin output load.
  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    seq_cnt_d   = seq_cnt_q;
    lfsr_d      = lfsr_q;
    rr_ptr_d    = rr_ptr_q;
    rvalid_d    = rvalid_q;
    rid_d       = rid_q;
    rdata_d     = rdata_q;
    arready_d   = 1'b0;
    alloc_found = 1'b0;
    alloc_idx   = '0;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    new_cnt     = (LAT_MODE == 1) ? MAX_LAT_CNT : 8'((lfsr_q % MAX_LAT_CNT) + 8'd1);

    accept  = s.s_arvalid_i && arready_q;
    load_en = !rvalid_q || s.s_rready_i;

    for (int i = 0; i < int'(DEPTH); i++) begin
      if (state_q[i] == SLOT_PEND) begin
        slot_d[i].cnt = slot_q[i].cnt - 8'd1;
        if (slot_q[i].cnt == 8'd1) begin
          state_d[i] = SLOT_READY;
        end
      end
    end

    // Descending scans leave the lowest free index / nearest-to-rr_ptr ready index.
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (state_q[i] == SLOT_FREE) begin
        alloc_found = 1'b1;
        alloc_idx   = PTR_W'(i);
      end
    end

    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      cand = PTR_W'((int'(rr_ptr_q) + k) % int'(DEPTH));
      if (state_q[cand] == SLOT_READY) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end

    if (accept && alloc_found) begin
      state_d[alloc_idx]     = SLOT_PEND;
      slot_d[alloc_idx].id   = s.s_arid_i;
      slot_d[alloc_idx].seq  = seq_cnt_q;
      slot_d[alloc_idx].cnt  = new_cnt;
      seq_cnt_d              = seq_cnt_q + DATA_WIDTH'(1);
      lfsr_d                 = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
    end

    if (load_en) begin
      if (grant_found) begin
        rvalid_d           = 1'b1;
        rid_d              = slot_q[grant_idx].id;
        rdata_d            = slot_q[grant_idx].seq;
        state_d[grant_idx] = SLOT_FREE;
        rr_ptr_d           = (grant_idx == PTR_W'(DEPTH - 1)) ? '0 : grant_idx + PTR_W'(1);
      end else begin
        rvalid_d = 1'b0;
      end
    end

    for (int i = 0; i < int'(DEPTH); i++) begin
      if (state_d[i] == SLOT_FREE) begin
        arready_d = 1'b1;
      end
    end
  end

  // State registers; reset drops every outstanding request and any latched beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        state_q[i] <= SLOT_FREE;
        slot_q[i]  <= '0;
      end
      seq_cnt_q <= '0;
      lfsr_q    <= LFSR_INIT;
      rr_ptr_q  <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      seq_cnt_q <= seq_cnt_d;
      lfsr_q    <= lfsr_d;
      rr_ptr_q  <= rr_ptr_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rid_q     <= rid_d;
      rdata_q   <= rdata_d;
    end
  end

endmodule

// File: tb/tb_ooo_read_responder.sv
// Directed + random bench for ooo_read_responder: a fixed-latency instance checks
// ordering/backpressure/reset, a random-latency 4-bit instance checks reordering and wrap.
module tb_ooo_read_responder;

  localparam int unsigned B_MAX_LAT = 7;
  localparam int unsigned B_DEPTH   = 4;

  typedef struct packed {
    logic [3:0] id;
    logic [7:0] seq;
  } exp_a_t;

  typedef struct {
    logic [3:0] id;
    logic [3:0] seq;
    int         t_acc;
    int         stall_acc;
  } exp_b_t;

  logic clk;
  logic rst;

  int vectors     = 0;
  int miscompares = 0;

  exp_a_t q_a[$];
  exp_b_t q_b[$];
  int     seq_a   = 0;
  int     seq_b   = 0;
  int     ret_b   = 0;
  int     zero_b  = 0;
  int     ooo_b   = 0;
  int     stall_b = 0;
  int     ecnt_b  = 0;

  ooo_read_responder_if #(.DATA_WIDTH(8)) ifa ();
  ooo_read_responder_if #(.DATA_WIDTH(4)) ifb ();

  ooo_read_responder #(
    .DATA_WIDTH(8), .DEPTH(4), .MAX_LAT(3), .LAT_MODE(1), .LFSR_SEED(8'hA5)
  ) u_fix (
    .clk(clk), .rst(rst), .s(ifa)
  );

  ooo_read_responder #(
    .DATA_WIDTH(4), .DEPTH(B_DEPTH), .MAX_LAT(B_MAX_LAT), .LAT_MODE(0), .LFSR_SEED(8'hA5)
  ) u_rnd (
    .clk(clk), .rst(rst), .s(ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    ifa.s_arvalid_i = 1'b0; ifa.s_arid_i = '0; ifa.s_rready_i = 1'b0;
    ifb.s_arvalid_i = 1'b0; ifb.s_arid_i = '0; ifb.s_rready_i = 1'b0;
  endtask

  task automatic reset_all();
    idle_inputs();
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(posedge clk); #1;
    q_a.delete(); q_b.delete();
    seq_a = 0; seq_b = 0; ret_b = 0; zero_b = 0; ooo_b = 0; stall_b = 0;
  endtask

  // One cycle on the fixed-latency instance; in-order scoreboard.
  task automatic cyc_a(input logic v, input logic [3:0] id, input logic rr);
    logic   ar_hs, r_hs;
    exp_a_t e;
    ifa.s_arvalid_i = v; ifa.s_arid_i = id; ifa.s_rready_i = rr;
    ar_hs = v && ifa.s_arready_o;
    r_hs  = ifa.s_rvalid_o && rr;
    if (ar_hs) begin
      q_a.push_back('{id: id, seq: 8'(seq_a)});
      seq_a++;
    end
    if (r_hs) begin
      if (q_a.size() == 0) begin
        check("a_spurious_beat", 32'(q_a.size()), 32'd1);
      end else begin
        e = q_a.pop_front();
        check("a_rid", 32'(ifa.s_rid_o), 32'(e.id));
        check("a_rdata", 32'(ifa.s_rdata_o), 32'(e.seq));
      end
    end
    @(posedge clk); #1;
  endtask

  // One cycle on the random-latency instance; search-by-seq scoreboard.
  task automatic cyc_b(input logic v, input logic [3:0] id, input logic rr);
    logic ar_hs, r_hs, found;
    int   idx, lat, bound;
    ifb.s_arvalid_i = v; ifb.s_arid_i = id; ifb.s_rready_i = rr;
    ar_hs = v && ifb.s_arready_o;
    r_hs  = ifb.s_rvalid_o && rr;
    if (ar_hs) begin
      q_b.push_back('{id: id, seq: 4'(seq_b), t_acc: ecnt_b + 1, stall_acc: stall_b});
      seq_b++;
    end
    if (r_hs) begin
      found = 1'b0;
      idx   = 0;
      for (int i = 0; i < q_b.size(); i++) begin
        if (!found && q_b[i].seq == ifb.s_rdata_o) begin
          found = 1'b1;
          idx   = i;
        end
      end
      check("b_known_seq", 32'(found), 32'd1);
      if (found) begin
        check("b_rid", 32'(ifb.s_rid_o), 32'(q_b[idx].id));
        lat   = ecnt_b + 1 - q_b[idx].t_acc;
        bound = int'(B_MAX_LAT) + 1 + int'(B_DEPTH) + (stall_b - q_b[idx].stall_acc);
        check("b_latency_bound", 32'(lat <= bound), 32'd1);
        if (idx != 0) ooo_b++;
        if (ifb.s_rdata_o == 4'd0) zero_b++;
        ret_b++;
        q_b.delete(idx);
      end
    end
    if (ifb.s_rvalid_o && !rr) stall_b++;
    @(posedge clk); #1;
    ecnt_b++;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();

    // Reset state.
    repeat (2) begin @(posedge clk); #1; end
    check("rst_arready", 32'(ifa.s_arready_o), 32'd0);
    check("rst_rvalid", 32'(ifa.s_rvalid_o), 32'd0);
    check("rst_rid", 32'(ifa.s_rid_o), 32'd0);
    check("rst_rdata", 32'(ifa.s_rdata_o), 32'd0);
    check("rst_b_rvalid", 32'(ifb.s_rvalid_o), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_arready", 32'(ifa.s_arready_o), 32'd1);
    check("idle_rvalid", 32'(ifa.s_rvalid_o), 32'd0);

    // Single request, fixed delay 3: beat visible 4 cycles after acceptance.
    cyc_a(1'b1, 4'd5, 1'b0);
    check("t1_rvalid_early", 32'(ifa.s_rvalid_o), 32'd0);
    for (int k = 0; k < 3; k++) begin
      cyc_a(1'b0, 4'd0, 1'b0);
      check("t1_rvalid_early", 32'(ifa.s_rvalid_o), 32'd0);
    end
    cyc_a(1'b0, 4'd0, 1'b0);
    check("t1_rvalid", 32'(ifa.s_rvalid_o), 32'd1);
    check("t1_rid", 32'(ifa.s_rid_o), 32'd5);
    check("t1_rdata", 32'(ifa.s_rdata_o), 32'd0);
    cyc_a(1'b0, 4'd0, 1'b1);
    check("t1_drained", 32'(ifa.s_rvalid_o), 32'd0);

    // Four back-to-back requests return in order at full rate.
    reset_all();
    for (int k = 1; k <= 4; k++) cyc_a(1'b1, 4'(k), 1'b1);
    for (int k = 0; k < 4; k++) begin
      cyc_a(1'b0, 4'd0, 1'b1);
      check("t2_back_to_back", 32'(ifa.s_rvalid_o), 32'd1);
    end
    cyc_a(1'b0, 4'd0, 1'b1);
    check("t2_rvalid_end", 32'(ifa.s_rvalid_o), 32'd0);
    check("t2_all_returned", 32'(q_a.size()), 32'd0);

    // Full with backpressure: DEPTH slots plus one latched beat, outputs held.
    reset_all();
    for (int c = 0; c < 16; c++) begin
      cyc_a(seq_a < 6, 4'(8 + seq_a), 1'b0);
      if (c >= 5) begin
        check("t3_arready_full", 32'(ifa.s_arready_o), 32'd0);
        check("t3_rvalid_hold", 32'(ifa.s_rvalid_o), 32'd1);
        check("t3_rid_hold", 32'(ifa.s_rid_o), 32'(q_a[0].id));
        check("t3_rdata_hold", 32'(ifa.s_rdata_o), 32'(q_a[0].seq));
      end
    end
    check("t3_accepted", 32'(seq_a), 32'd5);
    for (int c = 0; c < 60 && (seq_a < 6 || q_a.size() != 0); c++) begin
      cyc_a(seq_a < 6, 4'(8 + seq_a), 1'b1);
    end
    check("t3_drain_empty", 32'(q_a.size()), 32'd0);
    check("t3_drain_count", 32'(seq_a), 32'd6);
    check("t3_rvalid_end", 32'(ifa.s_rvalid_o), 32'd0);

    // Reset mid-flight: latched beat and pending slots are discarded.
    reset_all();
    for (int k = 0; k < 4; k++) cyc_a(1'b1, 4'(k + 1), 1'b0);
    cyc_a(1'b0, 4'd0, 1'b0);
    check("t6_beat_latched", 32'(ifa.s_rvalid_o), 32'd1);
    idle_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    check("t6_rst_rvalid", 32'(ifa.s_rvalid_o), 32'd0);
    check("t6_rst_rdata", 32'(ifa.s_rdata_o), 32'd0);
    check("t6_rst_arready", 32'(ifa.s_arready_o), 32'd0);
    rst = 1'b0;
    q_a.delete();
    seq_a = 0;
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) begin
      cyc_a(1'b0, 4'd0, 1'b1);
      check("t6_no_stale_beat", 32'(ifa.s_rvalid_o), 32'd0);
    end
    for (int k = 0; k < 4; k++) begin
      check("t6_slot_free", 32'(ifa.s_arready_o), 32'd1);
      cyc_a(1'b1, 4'(k + 10), 1'b1);
    end
    for (int c = 0; c < 30 && q_a.size() != 0; c++) cyc_a(1'b0, 4'd0, 1'b1);
    check("t6_post_reset_empty", 32'(q_a.size()), 32'd0);

    // Sequence wrap on a 4-bit data path.
    reset_all();
    for (int c = 0; c < 300 && (seq_b < 20 || q_b.size() != 0); c++) begin
      cyc_b(seq_b < 20, 4'(seq_b), 1'b1);
    end
    check("t5_empty", 32'(q_b.size()), 32'd0);
    check("t5_returned", 32'(ret_b), 32'd20);
    check("t5_zero_twice", 32'(zero_b), 32'd2);

    // Random traffic with random backpressure.
    reset_all();
    for (int c = 0; c < 4000 && seq_b < 200; c++) begin
      cyc_b(seq_b < 200 && $urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
            $urandom_range(0, 3) != 0);
    end
    for (int c = 0; c < 300 && q_b.size() != 0; c++) cyc_b(1'b0, 4'd0, 1'b1);
    check("t4_accepted", 32'(seq_b), 32'd200);
    check("t4_empty", 32'(q_b.size()), 32'd0);
    check("t4_returned", 32'(ret_b), 32'd200);
    check("t4_out_of_order_seen", 32'(ooo_b > 0), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
